// File: rtl/tristate_bus_ctrl_if.sv
// tristate_bus_ctrl_if: write-beat handshake and kill line for tristate_bus_ctrl
interface tristate_bus_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             wr_oe;
    logic             force_hiz;
    modport master (output wr_valid, wr_data, wr_oe, force_hiz, input wr_ready);
    modport slave (input wr_valid, wr_data, wr_oe, force_hiz, output wr_ready);
endinterface

// File: rtl/tristate_bus_ctrl.sv
// tristate_bus_ctrl: registered pad driver with bus-turnaround dead time and idle auto-release
module tristate_bus_ctrl #(
    parameter int WIDTH         = 8,
    parameter int DEAD_CYCLES   = 2,
    parameter int HOLD_CYCLES   = 0,
    parameter bit INV_DATA      = 1'b0,
    parameter bit OE_ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    tristate_bus_ctrl_if.slave   bus,
    output wire  [WIDTH-1:0]     pad_o,
    output logic                 busy,
    output logic [1:0]           state_o
);
    typedef enum logic [1:0] {HIZ = 2'b00, DRIVE = 2'b01, TURN = 2'b10} state_t;
    localparam logic [3:0] CNT_INIT = (DEAD_CYCLES == 0) ? 4'd0 : 4'(DEAD_CYCLES - 1);
    localparam logic [7:0] HOLD = 8'(HOLD_CYCLES);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       idle_q, idle_d, idle_inc;
    logic             drv_q, drv_d, busy_q, busy_d;
    logic             drive_req, accept, timeout, release_now;
    assign bus.wr_ready = !rst && !bus.force_hiz && state_q != TURN;
    assign state_o = state_q;
    assign busy = busy_q;
    // next-state: load data on drive beats, release on release beat / kill / idle timeout, count dead time
    always_comb begin
        drive_req   = bus.wr_oe ^ OE_ACTIVE_LOW;
        accept      = bus.wr_valid && bus.wr_ready;
        idle_inc    = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;
        timeout     = (HOLD_CYCLES != 0) && !accept && idle_inc >= HOLD;
        release_now = bus.force_hiz || (accept && !drive_req) || timeout;
        state_d     = state_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        idle_d      = 8'd0;
        case (state_q)
            HIZ: begin
                state_d = (accept && drive_req) ? DRIVE : HIZ;
                data_d  = (accept && drive_req) ? bus.wr_data : data_q;
            end
            DRIVE: begin
                state_d = release_now ? ((DEAD_CYCLES == 0) ? HIZ : TURN) : DRIVE;
                cnt_d   = release_now ? CNT_INIT : cnt_q;
                data_d  = (!release_now && accept) ? bus.wr_data : data_q;
                idle_d  = (release_now || accept) ? 8'd0 : idle_inc;
            end
            TURN: begin
                state_d = (cnt_q == 4'd0) ? HIZ : TURN;
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            end
            default: state_d = HIZ;
        endcase
        drv_d  = state_d == DRIVE;
        busy_d = state_d != HIZ;
    end
    // state and pad-control registers; reset drops the bus straight to high-Z
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HIZ;
            data_q  <= '0;
            cnt_q   <= 4'd0;
            idle_q  <= 8'd0;
            drv_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            drv_q   <= drv_d;
            busy_q  <= busy_d;
        end
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        O_BUFT u_buf (.I(data_q[i] ^ INV_DATA), .T(drv_q), .O(pad_o[i]));
    end
endmodule

// output buffer: T=1 drives I onto the pad, T=0 leaves it high-Z
module O_BUFT (
    input  logic I,
    input  logic T,
    output wire  O
);
    assign O = T ? I : 1'bz;
endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// tb_tristate_bus_ctrl: three parameter variants checked against a cycle-level behavioural model
module tb_tristate_bus_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst;
    logic       vld [3];
    logic       oe  [3];
    logic       fh  [3];
    logic [7:0] wd  [3];
    wire        rdy [3];
    wire  [1:0] st  [3];
    wire        bsy [3];
    wire  [7:0] pad [3];
    wire  [7:0] pad_a, pad_b, pad_c;
    int  dead_c [3] = '{2, 3, 0};
    int  hold_c [3] = '{0, 4, 0};
    bit  inv_c  [3] = '{1'b0, 1'b1, 1'b0};
    bit  oel_c  [3] = '{1'b0, 1'b0, 1'b1};
    bit         m_drv  [3];
    int         m_turn [3];
    int         m_idle [3];
    logic [7:0] m_data [3];
    logic       a_rdy  [3];
    logic       e_rdy  [3];
    int n_vec = 0;
    int n_err = 0;
    tristate_bus_ctrl_if #(.WIDTH(8)) ia ();
    tristate_bus_ctrl_if #(.WIDTH(8)) ib ();
    tristate_bus_ctrl_if #(.WIDTH(8)) ic ();
    assign ia.wr_valid = vld[0];
    assign ia.wr_data = wd[0];
    assign ia.wr_oe = oe[0];
    assign ia.force_hiz = fh[0];
    assign rdy[0] = ia.wr_ready;
    assign ib.wr_valid = vld[1];
    assign ib.wr_data = wd[1];
    assign ib.wr_oe = oe[1];
    assign ib.force_hiz = fh[1];
    assign rdy[1] = ib.wr_ready;
    assign ic.wr_valid = vld[2];
    assign ic.wr_data = wd[2];
    assign ic.wr_oe = oe[2];
    assign ic.force_hiz = fh[2];
    assign rdy[2] = ic.wr_ready;
    assign pad[0] = pad_a;
    assign pad[1] = pad_b;
    assign pad[2] = pad_c;
    tristate_bus_ctrl #(.WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave), .pad_o(pad_a), .busy(bsy[0]), .state_o(st[0]));
    tristate_bus_ctrl #(.WIDTH(8), .DEAD_CYCLES(3), .HOLD_CYCLES(4), .INV_DATA(1'b1)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave), .pad_o(pad_b), .busy(bsy[1]), .state_o(st[1]));
    tristate_bus_ctrl #(.WIDTH(8), .DEAD_CYCLES(0), .OE_ACTIVE_LOW(1'b1)) dut_c (
        .clk(clk), .rst(rst), .bus(ic.slave), .pad_o(pad_c), .busy(bsy[2]), .state_o(st[2]));

    function automatic logic [1:0] exp_st(input int k);
        return m_drv[k] ? 2'b01 : (m_turn[k] > 0 ? 2'b10 : 2'b00);
    endfunction

    function automatic logic [7:0] exp_pad(input int k);
        return m_data[k] ^ (inv_c[k] ? 8'hFF : 8'h00);
    endfunction

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0;
            fh[k] = 1'b0;
        end
    endtask

    task automatic beat(input int k, input logic [7:0] d, input bit drive);
        vld[k] = 1'b1;
        wd[k] = d;
        oe[k] = drive ^ oel_c[k];
    endtask

    // one clock: snapshot ready, advance the model, then sample #1 after the edge
    task automatic step();
        #1;
        for (int k = 0; k < 3; k++) begin
            bit req, acc, rel;
            a_rdy[k] = rdy[k];
            e_rdy[k] = !rst && !fh[k] && m_turn[k] == 0;
            req = oel_c[k] ? !oe[k] : oe[k];
            acc = vld[k] && e_rdy[k];
            if (rst) begin
                m_drv[k] = 1'b0;
                m_turn[k] = 0;
                m_idle[k] = 0;
                m_data[k] = 8'h00;
            end else if (m_turn[k] > 0) begin
                m_turn[k]--;
            end else if (!m_drv[k]) begin
                if (acc && req) begin
                    m_drv[k] = 1'b1;
                    m_data[k] = wd[k];
                    m_idle[k] = 0;
                end
            end else begin
                rel = fh[k] || (acc && !req) || (!acc && hold_c[k] > 0 && m_idle[k] + 1 >= hold_c[k]);
                if (rel) begin
                    m_drv[k] = 1'b0;
                    m_turn[k] = dead_c[k];
                    m_idle[k] = 0;
                end else if (acc) begin
                    m_data[k] = wd[k];
                    m_idle[k] = 0;
                end else if (m_idle[k] < 255) begin
                    m_idle[k]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) beat(k, 8'hFF, 1'b1);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            n_vec += 3;
            if (st[k] !== 2'b00) begin n_err++; $display("FAIL reset_state dut%0d: got %b expected 00", k, st[k]); end
            if (bsy[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy dut%0d: got %b expected 0", k, bsy[k]); end
            if (a_rdy[k] !== 1'b0) begin n_err++; $display("FAIL reset_ready dut%0d: got %b expected 0", k, a_rdy[k]); end
        end
    endtask

    task automatic test_first_beat();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) beat(k, 8'hA5, 1'b1);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] ep;
            ep = (k == 1) ? 8'h5A : 8'hA5;
            n_vec += 3;
            if (a_rdy[k] !== 1'b1) begin n_err++; $display("FAIL first_ready dut%0d: got %b expected 1", k, a_rdy[k]); end
            if (st[k] !== 2'b01) begin n_err++; $display("FAIL first_state dut%0d: got %b expected 01", k, st[k]); end
            if (pad[k] !== ep) begin n_err++; $display("FAIL first_pad dut%0d: got %h expected %h", k, pad[k], ep); end
        end
    endtask

    task automatic test_turnaround();
        beat(0, 8'h00, 1'b0);
        step();
        idle();
        n_vec += 2;
        if (st[0] !== 2'b10) begin n_err++; $display("FAIL turn_c11_state: got %b expected 10", st[0]); end
        if (bsy[0] !== 1'b1) begin n_err++; $display("FAIL turn_c11_busy: got %b expected 1", bsy[0]); end
        step();
        n_vec += 2;
        if (a_rdy[0] !== 1'b0) begin n_err++; $display("FAIL turn_c11_ready: got %b expected 0", a_rdy[0]); end
        if (st[0] !== 2'b10) begin n_err++; $display("FAIL turn_c12_state: got %b expected 10", st[0]); end
        step();
        n_vec += 2;
        if (a_rdy[0] !== 1'b0) begin n_err++; $display("FAIL turn_c12_ready: got %b expected 0", a_rdy[0]); end
        if (st[0] !== 2'b00) begin n_err++; $display("FAIL turn_c13_state: got %b expected 00", st[0]); end
        beat(0, 8'h3C, 1'b1);
        step();
        idle();
        n_vec += 3;
        if (a_rdy[0] !== 1'b1) begin n_err++; $display("FAIL turn_c13_ready: got %b expected 1", a_rdy[0]); end
        if (st[0] !== 2'b01) begin n_err++; $display("FAIL turn_c14_state: got %b expected 01", st[0]); end
        if (pad[0] !== 8'h3C) begin n_err++; $display("FAIL turn_c14_pad: got %h expected 3c", pad[0]); end
    endtask

    task automatic test_auto_release();
        int first;
        first = -1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        beat(1, 8'h11, 1'b1);
        step();
        idle();
        n_vec++;
        if (pad[1] !== 8'hEE) begin n_err++; $display("FAIL hold_pad: got %h expected ee", pad[1]); end
        for (int c = 1; c <= 8; c++) begin
            if (st[1] == 2'b10 && first < 0) first = c;
            step();
        end
        n_vec++;
        if (first !== 5) begin n_err++; $display("FAIL hold_turn_cycle: got %0d expected 5", first); end
    endtask

    task automatic test_force_hiz();
        beat(0, 8'h5A, 1'b1);
        beat(2, 8'h5A, 1'b1);
        step();
        n_vec += 2;
        if (st[0] !== 2'b01) begin n_err++; $display("FAIL force_pre_a: got %b expected 01", st[0]); end
        if (st[2] !== 2'b01) begin n_err++; $display("FAIL force_pre_c: got %b expected 01", st[2]); end
        fh[0] = 1'b1;
        fh[2] = 1'b1;
        beat(0, 8'h3C, 1'b1);
        beat(2, 8'h3C, 1'b1);
        step();
        idle();
        n_vec += 4;
        if (a_rdy[0] !== 1'b0) begin n_err++; $display("FAIL force_ready_a: got %b expected 0", a_rdy[0]); end
        if (a_rdy[2] !== 1'b0) begin n_err++; $display("FAIL force_ready_c: got %b expected 0", a_rdy[2]); end
        if (st[0] !== 2'b10) begin n_err++; $display("FAIL force_state_a: got %b expected 10", st[0]); end
        if (st[2] !== 2'b00) begin n_err++; $display("FAIL force_state_c: got %b expected 00", st[2]); end
    endtask

    task automatic test_dead_zero_and_reset();
        beat(2, 8'hC3, 1'b1);
        step();
        n_vec += 2;
        if (st[2] !== 2'b01) begin n_err++; $display("FAIL dz_drive_state: got %b expected 01", st[2]); end
        if (pad[2] !== 8'hC3) begin n_err++; $display("FAIL dz_drive_pad: got %h expected c3", pad[2]); end
        beat(2, 8'h00, 1'b0);
        step();
        idle();
        n_vec++;
        if (st[2] !== 2'b00) begin n_err++; $display("FAIL dz_release_state: got %b expected 00", st[2]); end
        beat(0, 8'h77, 1'b1);
        step();
        beat(0, 8'h00, 1'b0);
        step();
        idle();
        n_vec++;
        if (st[0] !== 2'b10) begin n_err++; $display("FAIL rst_turn_state: got %b expected 10", st[0]); end
        rst = 1'b1;
        step();
        n_vec += 2;
        if (st[0] !== 2'b00) begin n_err++; $display("FAIL rst_mid_turn_state: got %b expected 00", st[0]); end
        if (bsy[0] !== 1'b0) begin n_err++; $display("FAIL rst_mid_turn_busy: got %b expected 0", bsy[0]); end
        rst = 1'b0;
        beat(0, 8'h99, 1'b1);
        step();
        idle();
        n_vec += 3;
        if (a_rdy[0] !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b expected 1", a_rdy[0]); end
        if (st[0] !== 2'b01) begin n_err++; $display("FAIL post_rst_state: got %b expected 01", st[0]); end
        if (pad[0] !== 8'h99) begin n_err++; $display("FAIL post_rst_pad: got %h expected 99", pad[0]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom % 60) == 0;
            for (int k = 0; k < 3; k++) begin
                vld[k] = ($urandom % 3) == 0;
                wd[k] = 8'($urandom);
                oe[k] = ($urandom % 3) != 0;
                fh[k] = ($urandom % 12) == 0;
            end
            step();
            for (int k = 0; k < 3; k++) begin
                n_vec += 3;
                if (a_rdy[k] !== e_rdy[k]) begin n_err++; $display("FAIL rnd_ready dut%0d n=%0d: got %b expected %b", k, n, a_rdy[k], e_rdy[k]); end
                if (st[k] !== exp_st(k)) begin n_err++; $display("FAIL rnd_state dut%0d n=%0d: got %b expected %b", k, n, st[k], exp_st(k)); end
                if (bsy[k] !== (exp_st(k) != 2'b00)) begin n_err++; $display("FAIL rnd_busy dut%0d n=%0d: got %b expected %b", k, n, bsy[k], exp_st(k) != 2'b00); end
                if (m_drv[k]) begin
                    n_vec++;
                    if (pad[k] !== exp_pad(k)) begin n_err++; $display("FAIL rnd_pad dut%0d n=%0d: got %h expected %h", k, n, pad[k], exp_pad(k)); end
                end
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0;
            oe[k] = 1'b0;
            fh[k] = 1'b0;
            wd[k] = 8'h00;
            m_drv[k] = 1'b0;
            m_turn[k] = 0;
            m_idle[k] = 0;
            m_data[k] = 8'h00;
        end
        test_reset();
        test_first_beat();
        test_turnaround();
        test_auto_release();
        test_force_hiz();
        test_dead_zero_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tristate_bus_ctrl.md
TRISTATE_BUS_CTRL -- requirements
Module: tristate_bus_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning number of pad bits, legal 1..32.
REQ-002 The block SHALL have parameter DEAD_CYCLES, default 2, meaning bus-turnaround high-Z cycles after release, legal 0..15.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 0, meaning idle cycles in DRIVE before auto-release (0 = disabled), legal 0..255.
REQ-004 The block SHALL have parameter INV_DATA, default 0, meaning 1 = invert every data bit before the pad buffer.
REQ-005 The block SHALL have parameter OE_ACTIVE_LOW, default 0, meaning 1 = wr_oe value 0 requests drive.
REQ-006 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port wr_valid, input, 1, request beat valid.
REQ-009 Port wr_ready, output, 1, block accepts a beat; transfer when wr_valid && wr_ready.
REQ-010 Port wr_data, input, WIDTH, data to drive.
REQ-011 Port wr_oe, input, 1, drive request (polarity per OE_ACTIVE_LOW); deasserted = release bus.
REQ-012 Port force_hiz, input, 1, synchronous kill: release bus immediately.
REQ-013 Port pad_o, output, WIDTH, pad outputs, each bit driven by one O_BUFT primitive.
REQ-014 Port busy, output, 1, high in DRIVE or TURN.
REQ-015 Port state_o, output, 2, current state: 00 HIZ, 01 DRIVE, 10 TURN.

Function
REQ-016 Each O_BUFT bit SHALL take I = data_q[i] XOR INV_DATA and T = drv_q (T=1 drives, T=0 high-Z); data_q, drv_q SHALL be registers, no combinational path from inputs to I/T.
REQ-017 States SHALL be HIZ (drv_q=0), DRIVE (drv_q=1), TURN (drv_q=0, dead-time count).
REQ-018 wr_ready SHALL be 1 in HIZ and DRIVE, 0 in TURN, 0 while force_hiz=1, 0 during reset.
REQ-019 HIZ, accepted beat with drive request: data_q <= wr_data, next state DRIVE; pad driven with that data the cycle after acceptance (latency 1).
REQ-020 HIZ, accepted beat with release request: no state change, data_q unchanged.
REQ-021 DRIVE, accepted drive beat: data_q <= wr_data, stay DRIVE, idle counter cleared.
REQ-022 DRIVE, accepted release beat: data_q unchanged; next state TURN with cnt <= DEAD_CYCLES-1, or HIZ directly if DEAD_CYCLES=0.
REQ-023 TURN: cnt decrements each cycle; when cnt=0 next state HIZ; TURN lasts exactly DEAD_CYCLES cycles.
REQ-024 Minimum high-Z gap between two drive periods SHALL be DEAD_CYCLES+1 cycles (TURN plus one HIZ accept cycle).
REQ-025 Auto-release: with HOLD_CYCLES>0, idle counter counts DRIVE cycles without an accepted beat; on reaching HOLD_CYCLES, transition as REQ-022; counter saturates, never wraps.
REQ-026 force_hiz=1 in DRIVE SHALL transition as REQ-022 regardless of wr_valid; in TURN counting continues; in HIZ stay HIZ; force_hiz has priority over any beat the same cycle.
REQ-027 Release and auto-release timeout in the same cycle SHALL cause a single transition to TURN.
REQ-028 busy and state_o SHALL be registered state decodes, consistent with drv_q each cycle.

Reset
REQ-029 While rst=1: state HIZ, drv_q=0 (all pads high-Z), data_q=0, cnt=0, idle counter=0, wr_ready=0, busy=0, state_o=00.
REQ-030 rst asserted in DRIVE or TURN SHALL force high-Z on the next clock edge with no dead-time sequence; first beat accepted the cycle after rst deasserts.

Verification
REQ-031 Reset then beat (wr_data=0xA5, oe=1) at cycle 0 -> cycle 1: T=1, pad_o=0xA5, state_o=01; with INV_DATA=1 pad_o=0x5A.
REQ-032 DRIVE, release beat at cycle 10, DEAD_CYCLES=2 -> T=0 cycles 11-13, state_o=10 cycles 11-12, 00 at 13, wr_ready=0 cycles 11-12; drive beat at 13 drives at 14.
REQ-033 HOLD_CYCLES=4, drive beat then wr_valid=0 -> auto-release, state_o=10 exactly 5 cycles after acceptance.
REQ-034 force_hiz=1 with simultaneous drive beat 0x3C in DRIVE -> beat not accepted, data_q unchanged, T=0 next cycle.
REQ-035 DEAD_CYCLES=0, release beat -> state HIZ next cycle, no TURN; rst mid-TURN -> HIZ, cnt=0 next cycle.
REQ-036 OE_ACTIVE_LOW=1, beat with wr_oe=0 in HIZ -> DRIVE next cycle; wr_oe=1 -> release.
